sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Shares the single SDRAM command/address/data bus between four sequencers: power-up init, auto-refresh, burst write (the WR_IDLE..WR_END machine) and burst read.
- Grants exactly one sequencer at a time via level enables (aref_en, wr_en, rd_en). Muxes the granted sequencer's cmd/ba/addr onto the SDRAM pins and drives the tristate DQ bus.
- Sits between the sequencers and the SDRAM pads, inside the SDRAM controller top.

Parameters:
- NOP, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}
- IDLE_BA, 2'b11, bank value driven when no owner
- IDLE_ADDR, 11'h7ff, address value driven when no owner

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- init_cmd/init_ba/init_addr  in  4/2/11  init sequencer bus
- init_end  in  1  init done; level, stays high after init
- aref_req  in  1  refresh request, level
- aref_end  in  1  refresh done, 1-cycle pulse
- aref_cmd/aref_ba/aref_addr  in  4/2/11  refresh sequencer bus
- wr_req  in  1  write request, level
- wr_end  in  1  write done, 1-cycle pulse
- wr_cmd/wr_ba/wr_addr  in  4/2/11  write sequencer bus
- wr_sdram_en  in  1  write data output enable
- wr_sdram_data  in  32  write data
- rd_req  in  1  read request, level
- rd_end  in  1  read done, 1-cycle pulse
- rd_cmd/rd_ba/rd_addr  in  4/2/11  read sequencer bus
- aref_en/wr_en/rd_en  out  1 each  grant to the corresponding sequencer
- sdram_cke  out  1  clock enable
- sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank address
- sdram_addr  out  11  row/column address
- sdram_dq  inout  32  data bus

Behaviour:
- Clock is sys_clk. Reset is sys_rst_n, asynchronous active-low.
- Single registered state register, one-hot or binary. States: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- Transitions:
  - INIT -> ARBIT when init_end=1.
  - ARBIT selects a service by fixed priority aref_req > wr_req > rd_req: go to AREF, WRITE or READ respectively; otherwise stay in ARBIT.
  - AREF -> ARBIT on aref_end.
  - WRITE -> ARBIT on wr_end.
  - READ -> ARBIT on rd_end.
  - Unused encodings -> ARBIT.
- No preemption: a request of any priority arriving during a service waits until that service's end pulse.
- Minimum one ARBIT cycle between services. An end pulse and a new request in the same cycle never chain directly to the next service.
- Grants are combinational state decodes: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ).
  - Grant latency: request seen high in ARBIT at edge N -> grant high from cycle N+1.
  - Grant drops in the cycle after the end pulse, so a sequencer returning to idle never sees a stale enable.
- Command mux (combinational from state): {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n}, sdram_ba and sdram_addr are:
  - INIT -> init_*
  - AREF -> aref_*
  - WRITE -> wr_*
  - READ -> rd_*
  - ARBIT/default -> NOP, IDLE_BA, IDLE_ADDR
- While in reset, outputs are: state=INIT, so the pins show the init_* inputs; grants=0; sdram_cke=1; sdram_dq=Z.
- sdram_cke is constant 1'b1.
- sdram_dq = wr_sdram_data when wr_sdram_en=1, else 32'bz. Read data is taken from sdram_dq by the read sequencer, not registered here.
- A request deasserted before ARBIT samples it is lost; sequencers hold requests until granted.
- Reset asserted mid-service returns to INIT immediately. Grants drop asynchronously. DQ goes Z.

Test Plan:
- Reset, drive init_cmd=4'b0010, then init_end=1 at cycle 10 -> pins follow init_* until cycle 10; state ARBIT at cycle 11; pins show 4'b0111/2'b11/11'h7ff.
- In ARBIT, raise aref_req, wr_req and rd_req together -> aref_en=1 next cycle. After aref_end: one ARBIT cycle, then wr_en. After wr_end: one ARBIT cycle, then rd_en.
- During WRITE with wr_sdram_en=1 and wr_sdram_data=32'hA5A5_0001, raise aref_req -> no preemption, sdram_dq=32'hA5A5_0001. aref_en=1 only two cycles after wr_end.
- READ granted, rd_cmd=4'b0101 rd_ba=2'b01 rd_addr=11'h010 -> pins show exactly those values. sdram_dq is Z because wr_sdram_en=0.
- wr_end pulse coincident with wr_req still high -> ARBIT for one cycle with wr_en=0, then WRITE re-granted.
- sys_rst_n pulsed low mid-WRITE -> wr_en=0 asynchronously, sdram_dq=Z, state INIT. No grant until init_end=1 again.

Source files
------------

// File: rtl/sdram_arbit.sv
// Purpose: SDRAM bus arbiter; grants the shared cmd/ba/addr/dq pins to one of init, auto-refresh, write, read.
// Latency: request sampled in ARBIT at edge N -> grant from cycle N+1; pins are a combinational mux of the owner's bus.
// Backpressure: no preemption; requests wait (held level) until the owner's end pulse plus one ARBIT cycle.
//
// Ports:
//   sys_clk, sys_rst_n              clock, async active-low reset
//   init_*/aref_*/wr_*/rd_*         per-sequencer cmd(4)/ba(2)/addr(11), request levels, end pulses
//   wr_sdram_en, wr_sdram_data      write data and its output enable onto sdram_dq
//   aref_en, wr_en, rd_en           level grants (state decodes)
//   sdram_*                         SDRAM pad-side command/address pins and bidirectional dq
module sdram_arbit #(
    parameter logic [3:0]  NOP       = 4'b0111,
    parameter logic [1:0]  IDLE_BA   = 2'b11,
    parameter logic [10:0] IDLE_ADDR = 11'h7ff
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,

    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [10:0] init_addr,
    input  logic        init_end,

    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [10:0] aref_addr,

    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [10:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [31:0] wr_sdram_data,

    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [10:0] rd_addr,

    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,

    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [10:0] sdram_addr,
    inout  wire  [31:0] sdram_dq
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cmd_mux;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. Every service returns through ARBIT, so an end pulse
    // and a fresh request in the same cycle always leave one idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_end) state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req)     state_nxt = ST_AREF;
                else if (wr_req)  state_nxt = ST_WRITE;
                else if (rd_req)  state_nxt = ST_READ;
            end
            ST_AREF: begin
                if (aref_end) state_nxt = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_nxt = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) state_nxt = ST_ARBIT;
            end
            default: state_nxt = ST_ARBIT;
        endcase
    end

    // Outputs: grants and pin mux decode the state only, so an async
    // reset drops grants and hands the pins to the init sequencer at once.
    always_comb begin
        aref_en    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        cmd_mux    = NOP;
        sdram_ba   = IDLE_BA;
        sdram_addr = IDLE_ADDR;
        case (state)
            ST_INIT: begin
                cmd_mux    = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                aref_en    = 1'b1;
                cmd_mux    = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                wr_en      = 1'b1;
                cmd_mux    = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                rd_en      = 1'b1;
                cmd_mux    = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd_mux    = NOP;
                sdram_ba   = IDLE_BA;
                sdram_addr = IDLE_ADDR;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;

    assign sdram_cke = 1'b1;

    // Float DQ during reset even if the write sequencer still asserts its
    // enable, so the pads never fight the device while the controller restarts.
    assign sdram_dq = (wr_sdram_en && sys_rst_n) ? wr_sdram_data : 32'bz;

endmodule

// File: tb/tb_sdram_arbit.sv
// Purpose: self-checking bench for sdram_arbit; directed scenarios then randomized traffic vs an owner model.
// Latency: inputs driven at negedge, outputs checked 1 ns later, model advanced at posedge.
// Backpressure: sequencer stand-ins hold requests until granted.
module tb_sdram_arbit;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [10:0] init_addr;
    logic        init_end;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [10:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [10:0] wr_addr;
    logic        wr_sdram_en;
    logic [31:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [10:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [10:0] sdram_addr;
    wire  [31:0] sdram_dq;

    sdram_arbit dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq      (sdram_dq)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    // Owner model: -2 = still initialising, -1 = nobody (bus idle),
    // 0 = refresh, 1 = write, 2 = read (index is also the priority rank).
    localparam int OWN_INIT = -2;
    localparam int OWN_NONE = -1;
    int own = OWN_INIT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output with what the current owner implies.
    task automatic check_all();
        logic [16:0] exp_bus;
        logic [16:0] obs_bus;
        case (own)
            OWN_INIT: exp_bus = {init_cmd, init_ba, init_addr};
            0:        exp_bus = {aref_cmd, aref_ba, aref_addr};
            1:        exp_bus = {wr_cmd, wr_ba, wr_addr};
            2:        exp_bus = {rd_cmd, rd_ba, rd_addr};
            default:  exp_bus = {4'b0111, 2'b11, 11'h7ff};
        endcase
        obs_bus = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
        chk("aref_en", 32'(aref_en), 32'(own == 0));
        chk("wr_en",   32'(wr_en),   32'(own == 1));
        chk("rd_en",   32'(rd_en),   32'(own == 2));
        chk("pins",    32'(obs_bus), 32'(exp_bus));
        chk("cke",     32'(sdram_cke), 32'd1);
        if (sys_rst_n && wr_sdram_en)
            chk("dq", sdram_dq, wr_sdram_data);
        else
            chk("dq_z", 32'(sdram_dq === wr_sdram_data), 32'd0);
    endtask

    // One cycle: check settled outputs, advance the model on the edge,
    // return at the following negedge ready for new stimulus.
    task automatic step();
        logic [2:0] req;
        logic [2:0] done;
        if (!sys_rst_n) own = OWN_INIT;
        #1;
        check_all();
        @(posedge sys_clk);
        req  = {rd_req, wr_req, aref_req};
        done = {rd_end, wr_end, aref_end};
        if (!sys_rst_n) begin
            own = OWN_INIT;
        end else if (own == OWN_INIT) begin
            if (init_end) own = OWN_NONE;
        end else if (own == OWN_NONE) begin
            for (int s = 0; s < 3; s++) begin
                if (req[s]) begin
                    own = s;
                    break;
                end
            end
        end else if (done[own]) begin
            own = OWN_NONE;
        end
        @(negedge sys_clk);
    endtask

    task automatic rand_buses();
        init_cmd  = 4'($urandom);  init_ba = 2'($urandom);  init_addr = 11'($urandom);
        aref_cmd  = 4'($urandom);  aref_ba = 2'($urandom);  aref_addr = 11'($urandom);
        wr_cmd    = 4'($urandom);  wr_ba   = 2'($urandom);  wr_addr   = 11'($urandom);
        rd_cmd    = 4'($urandom);  rd_ba   = 2'($urandom);  rd_addr   = 11'($urandom);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rand_buses();
        init_cmd = 4'b0010;
        init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0;   wr_end = 1'b0;
        rd_req = 1'b0;   rd_end = 1'b0;
        wr_sdram_en = 1'b1;
        wr_sdram_data = 32'h1234_5678;

        // Reset: init bus on pins, no grants, DQ floated despite enable.
        @(negedge sys_clk);
        step();
        step();
        sys_rst_n = 1'b1;
        wr_sdram_en = 1'b0;
        for (int c = 0; c < 8; c++) step();
        chk("init_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h2);
        init_end = 1'b1;
        step();
        chk("arbit_cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'h7);
        chk("arbit_ba",  32'(sdram_ba), 32'h3);
        chk("arbit_addr", 32'(sdram_addr), 32'h7ff);

        // All three request together: refresh, write, read in order with gaps.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        chk("pri_aref", 32'(aref_en), 32'd1);
        aref_req = 1'b0; aref_end = 1'b1;
        step();
        chk("gap_after_aref", 32'({aref_en, wr_en, rd_en}), 32'd0);
        aref_end = 1'b0;
        step();
        chk("pri_wr", 32'(wr_en), 32'd1);

        // Refresh request during write must wait; DQ carries write data.
        wr_req = 1'b0;
        wr_sdram_en = 1'b1;
        wr_sdram_data = 32'hA5A5_0001;
        aref_req = 1'b1;
        step();
        chk("no_preempt", 32'({aref_en, wr_en}), 32'b01);
        chk("dq_write", sdram_dq, 32'hA5A5_0001);
        step();
        wr_end = 1'b1;
        step();
        chk("wr_end_gap", 32'({aref_en, wr_en}), 32'd0);
        wr_end = 1'b0;
        wr_sdram_en = 1'b0;
        step();
        chk("aref_after_wr", 32'(aref_en), 32'd1);
        aref_req = 1'b0; aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        step();
        chk("rd_grant", 32'(rd_en), 32'd1);

        // Read pins carry exactly the read bus; DQ is floated.
        rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 11'h010;
        #1;
        chk("rd_pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr}),
            32'({4'b0101, 2'b01, 11'h010}));
        rd_req = 1'b0; rd_end = 1'b1;
        step();
        rd_end = 1'b0;

        // End pulse with request still high: one idle cycle, then regrant.
        wr_req = 1'b1;
        step();
        chk("wr_regrant0", 32'(wr_en), 32'd1);
        wr_end = 1'b1;
        step();
        chk("wr_chain_gap", 32'(wr_en), 32'd0);
        wr_end = 1'b0;
        step();
        chk("wr_regrant1", 32'(wr_en), 32'd1);

        // Async reset mid-write: grant and DQ drop without a clock edge.
        wr_sdram_en = 1'b1;
        wr_sdram_data = 32'hDEAD_BEEF;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst_async_wr_en", 32'(wr_en), 32'd0);
        chk("rst_async_dq", 32'(sdram_dq === 32'hDEAD_BEEF), 32'd0);
        own = OWN_INIT;
        @(negedge sys_clk);
        init_end = 1'b0;
        step();
        sys_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("no_grant_before_init", 32'(wr_en), 32'd0);
        init_end = 1'b1;
        step();
        step();
        chk("grant_after_init", 32'(wr_en), 32'd1);
        wr_req = 1'b0; wr_end = 1'b1;
        step();
        wr_end = 1'b0;

        // Randomized traffic: held requests, stray end pulses, rare resets.
        for (int c = 0; c < 3000; c++) begin
            rand_buses();
            wr_sdram_en   = 1'($urandom_range(1));
            wr_sdram_data = $urandom | 32'h1;
            if (!aref_req) aref_req = ($urandom_range(5) == 0);
            else if (own == 0) aref_req = 1'($urandom_range(1));
            if (!wr_req) wr_req = ($urandom_range(3) == 0);
            else if (own == 1) wr_req = 1'($urandom_range(1));
            if (!rd_req) rd_req = ($urandom_range(3) == 0);
            else if (own == 2) rd_req = 1'($urandom_range(1));
            aref_end  = ($urandom_range(4) == 0);
            wr_end    = ($urandom_range(4) == 0);
            rd_end    = ($urandom_range(4) == 0);
            sys_rst_n = ($urandom_range(249) != 0);
            init_end  = ($urandom_range(7) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
